// File: rtl/jzjpcc_decode_execute_latch.sv
// Decode-to-execute pipeline register.
// Tracks instruction validity, honours flush and execute-hold, inserts a
// bubble on a load-use hazard, and forwards results from the memory and
// writeback stages onto the latched source operands.
module jzjpcc_decode_execute_latch #(
  parameter int PC_MAX_B       = 15,
  parameter int FORWARD_ENABLE = 1,
  parameter int BUBBLE_COUNT_W = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  // Decode stage
  input  logic                      dec_valid,
  input  logic [31:0]               dec_immediate,
  input  logic [31:0]               dec_rs1,
  input  logic [31:0]               dec_rs2,
  input  logic [4:0]                dec_rs1Addr,
  input  logic [4:0]                dec_rs2Addr,
  input  logic [4:0]                dec_rdAddr,
  input  logic [PC_MAX_B:2]         dec_currentPC,
  input  logic [2:0]                dec_aluOperation,
  input  logic                      dec_aluMod,
  input  logic [1:0]                dec_aluMuxMode,
  input  logic                      dec_rdWriteEnable,
  input  logic                      dec_memoryRead,
  // Pipeline control
  input  logic                      flush,
  input  logic                      ex_hold,
  // Later stages
  input  logic [4:0]                mem_rdAddr,
  input  logic [4:0]                wb_rdAddr,
  input  logic                      mem_rdWriteEnable,
  input  logic                      wb_rdWriteEnable,
  input  logic [31:0]               mem_rdData,
  input  logic [31:0]               wb_rdData,
  // Outputs
  output logic                      dec_stall,
  output logic                      ex_valid,
  output logic [31:0]               ex_immediate,
  output logic [31:0]               ex_rs1,
  output logic [31:0]               ex_rs2,
  output logic [PC_MAX_B:2]         ex_currentPC,
  output logic [4:0]                ex_rdAddr,
  output logic [2:0]                ex_aluOperation,
  output logic                      ex_aluMod,
  output logic [1:0]                ex_aluMuxMode,
  output logic                      ex_rdWriteEnable,
  output logic                      ex_memoryRead,
  output logic [BUBBLE_COUNT_W-1:0] bubbleCount
);

  // A producing stage matches a source register when it writes a non-zero
  // destination equal to that source; x0 never matches.
  function automatic logic f_reg_match(input logic       we,
                                       input logic [4:0] rd_addr,
                                       input logic [4:0] rs_addr);
    return we & (rd_addr != 5'd0) & (rd_addr == rs_addr);
  endfunction

  // Latched state
  logic                      r_valid;
  logic [31:0]               r_immediate;
  logic [31:0]               r_rs1;
  logic [31:0]               r_rs2;
  logic [4:0]                r_rs1Addr;
  logic [4:0]                r_rs2Addr;
  logic [4:0]                r_rdAddr;
  logic [PC_MAX_B:2]         r_currentPC;
  logic [2:0]                r_aluOperation;
  logic                      r_aluMod;
  logic [1:0]                r_aluMuxMode;
  logic                      r_rdWriteEnable;
  logic                      r_memoryRead;
  logic [BUBBLE_COUNT_W-1:0] r_bubbleCount;

  // Combinational helpers
  logic                      w_loadUse;
  logic [31:0]               w_rs1Capture;
  logic [31:0]               w_rs2Capture;
  logic [31:0]               w_rs1Fwd;
  logic [31:0]               w_rs2Fwd;

  // Load-use hazard: the latched load's destination feeds either source of
  // the decoding instruction. Both sources are compared regardless of
  // whether the instruction actually uses them (false hazards are harmless).
  always_comb begin
    w_loadUse = r_valid & r_memoryRead & dec_valid & (r_rdAddr != 5'd0) &
                ((r_rdAddr == dec_rs1Addr) | (r_rdAddr == dec_rs2Addr));
  end

  // Decode must hold while execute is busy or while a bubble is going in;
  // a flush kills the consumer so no stall is needed then. Reset forces 0.
  always_comb begin
    if (reset) begin
      dec_stall = 1'b0;
    end else begin
      dec_stall = ex_hold | (w_loadUse & ~flush);
    end
  end

  // Write-through of the writeback result into the operand being captured,
  // covering a register-file write in the same cycle as the read.
  always_comb begin
    w_rs1Capture = dec_rs1;
    w_rs2Capture = dec_rs2;
    if (f_reg_match(wb_rdWriteEnable, wb_rdAddr, dec_rs1Addr)) begin
      w_rs1Capture = wb_rdData;
    end else begin
      w_rs1Capture = dec_rs1;
    end
    if (f_reg_match(wb_rdWriteEnable, wb_rdAddr, dec_rs2Addr)) begin
      w_rs2Capture = wb_rdData;
    end else begin
      w_rs2Capture = dec_rs2;
    end
  end

  // Operand forwarding onto the latched operands; memory stage is younger
  // than writeback and therefore wins.
  always_comb begin
    w_rs1Fwd = r_rs1;
    w_rs2Fwd = r_rs2;
    if (FORWARD_ENABLE != 0) begin
      if (f_reg_match(mem_rdWriteEnable, mem_rdAddr, r_rs1Addr)) begin
        w_rs1Fwd = mem_rdData;
      end else if (f_reg_match(wb_rdWriteEnable, wb_rdAddr, r_rs1Addr)) begin
        w_rs1Fwd = wb_rdData;
      end else begin
        w_rs1Fwd = r_rs1;
      end
      if (f_reg_match(mem_rdWriteEnable, mem_rdAddr, r_rs2Addr)) begin
        w_rs2Fwd = mem_rdData;
      end else if (f_reg_match(wb_rdWriteEnable, wb_rdAddr, r_rs2Addr)) begin
        w_rs2Fwd = wb_rdData;
      end else begin
        w_rs2Fwd = r_rs2;
      end
    end else begin
      w_rs1Fwd = r_rs1;
      w_rs2Fwd = r_rs2;
    end
  end

  // Pipeline register update: flush beats hold, hold beats bubble, bubble
  // beats capture. Write-enable and load flags are stored already qualified
  // by validity so they can be driven straight from flops.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_valid         <= 1'b0;
      r_immediate     <= 32'd0;
      r_rs1           <= 32'd0;
      r_rs2           <= 32'd0;
      r_rs1Addr       <= 5'd0;
      r_rs2Addr       <= 5'd0;
      r_rdAddr        <= 5'd0;
      r_currentPC     <= '0;
      r_aluOperation  <= 3'd0;
      r_aluMod        <= 1'b0;
      r_aluMuxMode    <= 2'd0;
      r_rdWriteEnable <= 1'b0;
      r_memoryRead    <= 1'b0;
      r_bubbleCount   <= '0;
    end else if (flush) begin
      r_valid         <= 1'b0;
      r_rdWriteEnable <= 1'b0;
      r_memoryRead    <= 1'b0;
    end else if (ex_hold) begin
      r_valid         <= r_valid;
    end else if (w_loadUse) begin
      r_valid         <= 1'b0;
      r_rdWriteEnable <= 1'b0;
      r_memoryRead    <= 1'b0;
      if (r_bubbleCount != {BUBBLE_COUNT_W{1'b1}}) begin
        r_bubbleCount <= r_bubbleCount + BUBBLE_COUNT_W'(1);
      end else begin
        r_bubbleCount <= r_bubbleCount;
      end
    end else begin
      r_valid         <= dec_valid;
      r_immediate     <= dec_immediate;
      r_rs1           <= w_rs1Capture;
      r_rs2           <= w_rs2Capture;
      r_rs1Addr       <= dec_rs1Addr;
      r_rs2Addr       <= dec_rs2Addr;
      r_rdAddr        <= dec_rdAddr;
      r_currentPC     <= dec_currentPC;
      r_aluOperation  <= dec_aluOperation;
      r_aluMod        <= dec_aluMod;
      r_aluMuxMode    <= dec_aluMuxMode;
      r_rdWriteEnable <= dec_rdWriteEnable & dec_valid;
      r_memoryRead    <= dec_memoryRead & dec_valid;
    end
  end

  // Output drive
  always_comb begin
    ex_valid         = r_valid;
    ex_immediate     = r_immediate;
    ex_rs1           = w_rs1Fwd;
    ex_rs2           = w_rs2Fwd;
    ex_currentPC     = r_currentPC;
    ex_rdAddr        = r_rdAddr;
    ex_aluOperation  = r_aluOperation;
    ex_aluMod        = r_aluMod;
    ex_aluMuxMode    = r_aluMuxMode;
    ex_rdWriteEnable = r_rdWriteEnable;
    ex_memoryRead    = r_memoryRead;
    bubbleCount      = r_bubbleCount;
  end

endmodule

// File: tb/tb_jzjpcc_decode_execute_latch.sv
// Directed bench for jzjpcc_decode_execute_latch. A default instance (u_dut)
// and a narrow, non-forwarding instance (u_nf) share the same stimulus.
module tb_jzjpcc_decode_execute_latch;

  logic        clock = 1'b0;
  logic        reset;
  logic        dec_valid;
  logic [31:0] dec_immediate, dec_rs1, dec_rs2;
  logic [4:0]  dec_rs1Addr, dec_rs2Addr, dec_rdAddr;
  logic [15:2] dec_currentPC;
  logic [2:0]  dec_aluOperation;
  logic        dec_aluMod;
  logic [1:0]  dec_aluMuxMode;
  logic        dec_rdWriteEnable, dec_memoryRead;
  logic        flush, ex_hold;
  logic [4:0]  mem_rdAddr, wb_rdAddr;
  logic        mem_rdWriteEnable, wb_rdWriteEnable;
  logic [31:0] mem_rdData, wb_rdData;

  logic        dec_stall, ex_valid, ex_aluMod, ex_rdWriteEnable, ex_memoryRead;
  logic [31:0] ex_immediate, ex_rs1, ex_rs2;
  logic [15:2] ex_currentPC;
  logic [4:0]  ex_rdAddr;
  logic [2:0]  ex_aluOperation;
  logic [1:0]  ex_aluMuxMode;
  logic [15:0] bubbleCount;

  logic        n_dec_stall, n_ex_valid, n_ex_aluMod, n_ex_rdWriteEnable, n_ex_memoryRead;
  logic [31:0] n_ex_immediate, n_ex_rs1, n_ex_rs2;
  logic [15:2] n_ex_currentPC;
  logic [4:0]  n_ex_rdAddr;
  logic [2:0]  n_ex_aluOperation;
  logic [1:0]  n_ex_aluMuxMode;
  logic [2:0]  n_bubbleCount;

  int n_tests = 0;
  int n_fail  = 0;

  jzjpcc_decode_execute_latch u_dut (
    .clock(clock), .reset(reset),
    .dec_valid(dec_valid), .dec_immediate(dec_immediate),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .dec_rs1Addr(dec_rs1Addr), .dec_rs2Addr(dec_rs2Addr), .dec_rdAddr(dec_rdAddr),
    .dec_currentPC(dec_currentPC), .dec_aluOperation(dec_aluOperation),
    .dec_aluMod(dec_aluMod), .dec_aluMuxMode(dec_aluMuxMode),
    .dec_rdWriteEnable(dec_rdWriteEnable), .dec_memoryRead(dec_memoryRead),
    .flush(flush), .ex_hold(ex_hold),
    .mem_rdAddr(mem_rdAddr), .wb_rdAddr(wb_rdAddr),
    .mem_rdWriteEnable(mem_rdWriteEnable), .wb_rdWriteEnable(wb_rdWriteEnable),
    .mem_rdData(mem_rdData), .wb_rdData(wb_rdData),
    .dec_stall(dec_stall), .ex_valid(ex_valid), .ex_immediate(ex_immediate),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_currentPC(ex_currentPC),
    .ex_rdAddr(ex_rdAddr), .ex_aluOperation(ex_aluOperation),
    .ex_aluMod(ex_aluMod), .ex_aluMuxMode(ex_aluMuxMode),
    .ex_rdWriteEnable(ex_rdWriteEnable), .ex_memoryRead(ex_memoryRead),
    .bubbleCount(bubbleCount)
  );

  jzjpcc_decode_execute_latch #(.PC_MAX_B(15), .FORWARD_ENABLE(0), .BUBBLE_COUNT_W(3)) u_nf (
    .clock(clock), .reset(reset),
    .dec_valid(dec_valid), .dec_immediate(dec_immediate),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .dec_rs1Addr(dec_rs1Addr), .dec_rs2Addr(dec_rs2Addr), .dec_rdAddr(dec_rdAddr),
    .dec_currentPC(dec_currentPC), .dec_aluOperation(dec_aluOperation),
    .dec_aluMod(dec_aluMod), .dec_aluMuxMode(dec_aluMuxMode),
    .dec_rdWriteEnable(dec_rdWriteEnable), .dec_memoryRead(dec_memoryRead),
    .flush(flush), .ex_hold(ex_hold),
    .mem_rdAddr(mem_rdAddr), .wb_rdAddr(wb_rdAddr),
    .mem_rdWriteEnable(mem_rdWriteEnable), .wb_rdWriteEnable(wb_rdWriteEnable),
    .mem_rdData(mem_rdData), .wb_rdData(wb_rdData),
    .dec_stall(n_dec_stall), .ex_valid(n_ex_valid), .ex_immediate(n_ex_immediate),
    .ex_rs1(n_ex_rs1), .ex_rs2(n_ex_rs2), .ex_currentPC(n_ex_currentPC),
    .ex_rdAddr(n_ex_rdAddr), .ex_aluOperation(n_ex_aluOperation),
    .ex_aluMod(n_ex_aluMod), .ex_aluMuxMode(n_ex_aluMuxMode),
    .ex_rdWriteEnable(n_ex_rdWriteEnable), .ex_memoryRead(n_ex_memoryRead),
    .bubbleCount(n_bubbleCount)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and step 1 time unit past it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    dec_valid = 1'b0; dec_immediate = 32'd0; dec_rs1 = 32'd0; dec_rs2 = 32'd0;
    dec_rs1Addr = 5'd0; dec_rs2Addr = 5'd0; dec_rdAddr = 5'd0; dec_currentPC = 14'd0;
    dec_aluOperation = 3'd0; dec_aluMod = 1'b0; dec_aluMuxMode = 2'd0;
    dec_rdWriteEnable = 1'b0; dec_memoryRead = 1'b0;
    flush = 1'b0; ex_hold = 1'b1;
    mem_rdAddr = 5'd0; wb_rdAddr = 5'd0; mem_rdWriteEnable = 1'b0; wb_rdWriteEnable = 1'b0;
    mem_rdData = 32'd0; wb_rdData = 32'd0;
    #12;
    // Reset state, with ex_hold high to show reset masks the stall
    chk("rst_valid", {31'd0, ex_valid}, 32'd0);
    chk("rst_bubbles", {16'd0, bubbleCount}, 32'd0);
    chk("rst_stall", {31'd0, dec_stall}, 32'd0);
    reset = 1'b0; ex_hold = 1'b0;

    // Plain capture
    dec_valid = 1'b1; dec_rs1 = 32'h11; dec_rs2 = 32'h22; dec_currentPC = 14'h40;
    dec_rdAddr = 5'd5; dec_rs1Addr = 5'd1; dec_rs2Addr = 5'd2;
    dec_aluOperation = 3'd3; dec_immediate = 32'h1234; dec_rdWriteEnable = 1'b1;
    #1 chk("cap_stall_pre", {31'd0, dec_stall}, 32'd0);
    tick();
    chk("cap_valid", {31'd0, ex_valid}, 32'd1);
    chk("cap_rs1", ex_rs1, 32'h11);
    chk("cap_rs2", ex_rs2, 32'h22);
    chk("cap_rd", {27'd0, ex_rdAddr}, 32'd5);
    chk("cap_pc", {18'd0, ex_currentPC}, 32'h40);
    chk("cap_imm", ex_immediate, 32'h1234);
    chk("cap_aluop", {29'd0, ex_aluOperation}, 32'd3);
    chk("cap_we", {31'd0, ex_rdWriteEnable}, 32'd1);
    chk("cap_stall", {31'd0, dec_stall}, 32'd0);

    // Load-use: load rd=3, then consumer reading r3 through rs2
    dec_memoryRead = 1'b1; dec_rdAddr = 5'd3; dec_rs1Addr = 5'd1; dec_rs2Addr = 5'd2;
    tick();
    chk("ld_memrd", {31'd0, ex_memoryRead}, 32'd1);
    dec_memoryRead = 1'b0; dec_rdAddr = 5'd6; dec_rs1Addr = 5'd4; dec_rs2Addr = 5'd3;
    dec_rs1 = 32'h44; dec_rs2 = 32'h0;
    #1 chk("lu_stall", {31'd0, dec_stall}, 32'd1);
    tick();
    chk("lu_bubble_valid", {31'd0, ex_valid}, 32'd0);
    chk("lu_bubble_we", {31'd0, ex_rdWriteEnable}, 32'd0);
    chk("lu_bubble_memrd", {31'd0, ex_memoryRead}, 32'd0);
    chk("lu_count", {16'd0, bubbleCount}, 32'd1);
    chk("lu_count_nf", {29'd0, n_bubbleCount}, 32'd1);
    chk("lu_stall_released", {31'd0, dec_stall}, 32'd0);
    mem_rdAddr = 5'd3; mem_rdWriteEnable = 1'b1; mem_rdData = 32'hDEAD;
    tick();
    chk("lu_cons_valid", {31'd0, ex_valid}, 32'd1);
    chk("lu_cons_rd", {27'd0, ex_rdAddr}, 32'd6);
    chk("lu_cons_rs2_fwd", ex_rs2, 32'hDEAD);
    chk("lu_cons_rs1", ex_rs1, 32'h44);
    chk("lu_cons_rs2_nf", n_ex_rs2, 32'h0);
    chk("lu_count_after", {16'd0, bubbleCount}, 32'd1);
    mem_rdWriteEnable = 1'b0; mem_rdAddr = 5'd0;

    // Forward priority on latched rs1Addr=7
    dec_rs1Addr = 5'd7; dec_rs1 = 32'h77; dec_rs2Addr = 5'd8; dec_rs2 = 32'h88; dec_rdAddr = 5'd9;
    tick();
    chk("fw_raw", ex_rs1, 32'h77);
    mem_rdAddr = 5'd7; mem_rdWriteEnable = 1'b1; mem_rdData = 32'hA;
    wb_rdAddr = 5'd7; wb_rdWriteEnable = 1'b1; wb_rdData = 32'hB;
    #1 chk("fw_mem_over_wb", ex_rs1, 32'hA);
    chk("fw_rs2_untouched", ex_rs2, 32'h88);
    chk("fw_nf_raw", n_ex_rs1, 32'h77);
    mem_rdWriteEnable = 1'b0;
    #1 chk("fw_wb_only", ex_rs1, 32'hB);
    mem_rdWriteEnable = 1'b1; mem_rdAddr = 5'd0; wb_rdAddr = 5'd0;
    #1 chk("fw_x0_raw", ex_rs1, 32'h77);
    mem_rdWriteEnable = 1'b0; wb_rdWriteEnable = 1'b0;

    // Write-through at capture: wb writes r9=0x55 while decode reads r9
    wb_rdWriteEnable = 1'b1; wb_rdAddr = 5'd9; wb_rdData = 32'h55;
    dec_rs1Addr = 5'd9; dec_rs1 = 32'h0; dec_rs2Addr = 5'd2; dec_rs2 = 32'h22; dec_rdAddr = 5'd12;
    tick();
    wb_rdWriteEnable = 1'b0; wb_rdAddr = 5'd0;
    #1 chk("wt_rs1", ex_rs1, 32'h55);
    chk("wt_rs1_nf", n_ex_rs1, 32'h55);
    chk("wt_rs2", ex_rs2, 32'h22);
    chk("wt_we", {31'd0, ex_rdWriteEnable}, 32'd1);

    // Flush together with hold kills the latched instruction
    ex_hold = 1'b1; flush = 1'b1;
    #1 chk("fh_stall", {31'd0, dec_stall}, 32'd1);
    tick();
    chk("fh_valid", {31'd0, ex_valid}, 32'd0);
    chk("fh_we", {31'd0, ex_rdWriteEnable}, 32'd0);
    ex_hold = 1'b0; flush = 1'b0;

    // Capture, then hold for three cycles while decode changes
    dec_rs1Addr = 5'd11; dec_rs1 = 32'h31; dec_rs2Addr = 5'd12; dec_rs2 = 32'h32;
    dec_rdAddr = 5'd10; dec_currentPC = 14'h55;
    tick();
    chk("hold_cap_rd", {27'd0, ex_rdAddr}, 32'd10);
    ex_hold = 1'b1;
    dec_rs1 = 32'hFF; dec_rdAddr = 5'd20; dec_currentPC = 14'h7;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_valid", {31'd0, ex_valid}, 32'd1);
      chk("hold_rd", {27'd0, ex_rdAddr}, 32'd10);
      chk("hold_rs1", ex_rs1, 32'h31);
      chk("hold_pc", {18'd0, ex_currentPC}, 32'h55);
      chk("hold_stall", {31'd0, dec_stall}, 32'd1);
    end

    // Reset asserted mid-hold clears outputs before the next edge
    reset = 1'b1;
    #1;
    chk("arst_valid", {31'd0, ex_valid}, 32'd0);
    chk("arst_rs1", ex_rs1, 32'd0);
    chk("arst_rd", {27'd0, ex_rdAddr}, 32'd0);
    chk("arst_pc", {18'd0, ex_currentPC}, 32'd0);
    chk("arst_we", {31'd0, ex_rdWriteEnable}, 32'd0);
    chk("arst_bubbles", {16'd0, bubbleCount}, 32'd0);
    chk("arst_stall", {31'd0, dec_stall}, 32'd0);
    #1 reset = 1'b0; ex_hold = 1'b0;

    // Saturation: a load that depends on itself alternates capture/bubble
    dec_memoryRead = 1'b1; dec_rdAddr = 5'd3; dec_rs1Addr = 5'd3; dec_rs2Addr = 5'd0;
    dec_rdWriteEnable = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) begin
      tick();
      tick();
    end
    chk("sat_count", {16'd0, bubbleCount}, 32'd10);
    chk("sat_count_nf", {29'd0, n_bubbleCount}, 32'd7);
    chk("sat_valid", {31'd0, ex_valid}, 32'd1);

    // Flush suppresses the stall and the bubble count
    flush = 1'b1;
    #1 chk("fl_nostall", {31'd0, dec_stall}, 32'd0);
    tick();
    chk("fl_valid", {31'd0, ex_valid}, 32'd0);
    chk("fl_count", {16'd0, bubbleCount}, 32'd10);
    flush = 1'b0;

    // A load to x0 never creates a hazard
    dec_rdAddr = 5'd0; dec_rs1Addr = 5'd0; dec_rs2Addr = 5'd0;
    tick();
    chk("x0_stall", {31'd0, dec_stall}, 32'd0);
    tick();
    chk("x0_valid", {31'd0, ex_valid}, 32'd1);
    chk("x0_count", {16'd0, bubbleCount}, 32'd10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
